// File: rtl/imem_prog.sv
// imem_prog: loadable instruction memory with a one-cycle registered fetch port.
// Define IMEM_FAULT_EN to return NOP_WORD with fetch_fault on misaligned/out-of-range fetches.
module imem_prog #(
    parameter int                   WORD_SIZE = 32,
    parameter int                   DEPTH     = 256,
    parameter logic [WORD_SIZE-1:0] NOP_WORD  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fetch_valid,
    input  logic [WORD_SIZE-1:0] fetch_addr,
    output logic                 fetch_ready,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instruction,
    input  logic                 instr_ready,
    output logic                 fetch_fault,
    input  logic                 load_start,
    input  logic                 load_valid,
    input  logic [WORD_SIZE-1:0] load_data,
    input  logic                 load_last,
    output logic                 load_ready,
    output logic                 load_done,
    output logic                 busy
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        RUN  = 1'b0,
        LOAD = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic                 valid_q, valid_d;
    logic [WORD_SIZE-1:0] instr_q, instr_d;
    logic                 fault_q, fault_d;
    logic                 done_q, done_d;
    logic [WORD_SIZE-1:0] mem_q [DEPTH];

    logic                 is_load;
    logic                 fetch_acc;
    logic                 load_acc;
    logic                 addr_bad;
    logic [AW-1:0]        idx;

    assign idx = fetch_addr[AW+1:2];

`ifdef IMEM_FAULT_EN
    assign addr_bad = (fetch_addr[1:0] != 2'b00)
                   || (fetch_addr[WORD_SIZE-1:AW+2] != '0);
`else
    // Byte offset and upper bits alias onto the word index.
    logic unused_addr;
    assign unused_addr = ^{fetch_addr[1:0], fetch_addr[WORD_SIZE-1:AW+2]};
    assign addr_bad    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RUN;
            ptr_q   <= '0;
            valid_q <= 1'b0;
            instr_q <= NOP_WORD;
            fault_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            fault_q <= fault_d;
            done_q  <= done_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (load_acc) begin
            mem_q[ptr_q] <= load_data;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        instr_d = instr_q;
        fault_d = fault_q;
        done_d  = 1'b0;
        unique case (state_q)
            RUN: begin
                if (load_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                if (load_acc) begin
                    ptr_d  = ptr_q + AW'(1);
                    done_d = load_last;
                    if (load_last) begin
                        state_d = RUN;
                    end
                end
            end
            default: ;
        endcase
        if (fetch_acc) begin
            valid_d = 1'b1;
            fault_d = addr_bad;
            instr_d = addr_bad ? NOP_WORD : mem_q[idx];
        end else if (instr_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        is_load     = (state_q == LOAD);
        busy        = is_load;
        load_ready  = is_load;
        fetch_ready = !is_load && (!valid_q || instr_ready);
        fetch_acc   = fetch_valid && fetch_ready;
        load_acc    = load_valid && is_load;
    end

    assign instr_valid = valid_q;
    assign instruction = instr_q;
    assign fetch_fault = fault_q;
    assign load_done   = done_q;

endmodule

// File: tb/tb_imem_prog.sv
// tb_imem_prog: table-driven fetch vectors with a response scoreboard,
// plus directed load, stall, wrap and reset sequences.
module tb_imem_prog;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        fetch_valid;
    logic [31:0] fetch_addr;
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        instr_ready;
    logic        fetch_fault;
    logic        load_start;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_last;
    logic        load_ready;
    logic        load_done;
    logic        busy;

    logic        s_fetch_valid;
    logic [31:0] s_fetch_addr;
    logic        s_fetch_ready;
    logic        s_instr_valid;
    logic [31:0] s_instruction;
    logic        s_instr_ready;
    logic        s_fetch_fault;
    logic        s_load_start;
    logic        s_load_valid;
    logic [31:0] s_load_data;
    logic        s_load_last;
    logic        s_load_ready;
    logic        s_load_done;
    logic        s_busy;

    int   vecs;
    int   errs;
    exp_t sb_q[$];
    logic [31:0] cur_exp;
    logic        cur_fault;
    vec_t tbl[7];

    imem_prog #(.WORD_SIZE(32), .DEPTH(256), .NOP_WORD(NOP)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .fetch_valid(fetch_valid), .fetch_addr(fetch_addr),
        .fetch_ready(fetch_ready), .instr_valid(instr_valid),
        .instruction(instruction), .instr_ready(instr_ready),
        .fetch_fault(fetch_fault), .load_start(load_start),
        .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready),
        .load_done(load_done), .busy(busy)
    );

    imem_prog #(.WORD_SIZE(32), .DEPTH(4), .NOP_WORD(NOP)) u_small (
        .clk(clk), .rst_n(rst_n),
        .fetch_valid(s_fetch_valid), .fetch_addr(s_fetch_addr),
        .fetch_ready(s_fetch_ready), .instr_valid(s_instr_valid),
        .instruction(s_instruction), .instr_ready(s_instr_ready),
        .fetch_fault(s_fetch_fault), .load_start(s_load_start),
        .load_valid(s_load_valid), .load_data(s_load_data),
        .load_last(s_load_last), .load_ready(s_load_ready),
        .load_done(s_load_done), .busy(s_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Inputs are set just after a negedge; handshakes are sampled 1 ns later.
    task automatic tick();
        exp_t e;
        #1;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (instr_valid && instr_ready) begin
                if (sb_q.size() == 0) begin
                    vecs++;
                    errs++;
                    $display("FAIL sb_empty: got response %h want none", instruction);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_instr", instruction, e.data);
                    chk("sb_fault", {31'b0, fetch_fault}, {31'b0, e.fault});
                end
            end
            if (fetch_valid && fetch_ready) begin
                sb_q.push_back('{cur_exp, cur_fault});
            end
        end
        @(negedge clk);
    endtask

    task automatic load_beat(input logic [31:0] d, input logic last);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                         input logic f);
        fetch_valid = 1'b1;
        fetch_addr  = a;
        instr_ready = 1'b1;
        cur_exp     = d;
        cur_fault   = f;
        tick();
        fetch_valid = 1'b0;
        chk("lat_valid", {31'b0, instr_valid}, 32'd1);
        chk("lat_instr", instruction, d);
    endtask

    task automatic drain();
        fetch_valid = 1'b0;
        instr_ready = 1'b1;
        tick();
        chk("drain_valid", {31'b0, instr_valid}, 32'd0);
    endtask

    task automatic s_load(input logic [31:0] d, input logic last);
        s_load_valid = 1'b1;
        s_load_data  = d;
        s_load_last  = last;
        tick();
        s_load_valid = 1'b0;
        s_load_last  = 1'b0;
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        tbl[0] = '{32'h0, 32'h1111_1111, 1'b0};
        tbl[1] = '{32'h4, 32'h2222_2222, 1'b0};
        tbl[2] = '{32'h8, 32'h3333_3333, 1'b0};
        tbl[3] = '{32'hC, 32'h4444_4444, 1'b0};
`ifdef IMEM_FAULT_EN
        tbl[4] = '{32'h6,   NOP,          1'b1};
        tbl[5] = '{32'h400, NOP,          1'b1};
        tbl[6] = '{32'h4,   32'h2222_2222, 1'b0};
`else
        tbl[4] = '{32'h6,   32'h2222_2222, 1'b0};
        tbl[5] = '{32'h400, 32'h1111_1111, 1'b0};
        tbl[6] = '{32'h40D, 32'h4444_4444, 1'b0};
`endif
        rst_n = 1'b0;
        fetch_valid = 0; fetch_addr = 0; instr_ready = 0;
        load_start = 0; load_valid = 0; load_data = 0; load_last = 0;
        s_fetch_valid = 0; s_fetch_addr = 0; s_instr_ready = 1;
        s_load_start = 0; s_load_valid = 0; s_load_data = 0; s_load_last = 0;
        cur_exp = 0; cur_fault = 0;
        tick();
        tick();
        chk("rst_valid", {31'b0, instr_valid}, 32'd0);
        chk("rst_instr", instruction, NOP);
        chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_lready", {31'b0, load_ready}, 32'd0);
        chk("rst_done", {31'b0, load_done}, 32'd0);
        chk("rst_fready", {31'b0, fetch_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // DEPTH=4 wrap: fifth word overwrites word 0.
        s_load_start = 1'b1;
        tick();
        s_load_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_load(32'hA + i, i == 4);
        end
        chk("wrap_done", {31'b0, s_load_done}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            s_fetch_valid = 1'b1;
            s_fetch_addr  = 32'(i * 4);
            tick();
            chk("wrap_word", s_instruction, (i == 0) ? 32'hE : 32'hA + i);
        end
        s_fetch_valid = 1'b0;
        tick();

        // Initial program load.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        chk("load_busy", {31'b0, busy}, 32'd1);
        chk("load_ready", {31'b0, load_ready}, 32'd1);
        chk("load_fready", {31'b0, fetch_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            load_beat(32'h1111_1111 * (i + 1), i == 3);
            if (i < 3) chk("load_nodone", {31'b0, load_done}, 32'd0);
        end
        chk("done_pulse", {31'b0, load_done}, 32'd1);
        chk("done_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("done_clear", {31'b0, load_done}, 32'd0);

        // Back-to-back fetches from the table.
        for (int i = 0; i < 7; i++) begin
            fetch_valid = 1'b1;
            fetch_addr  = tbl[i].addr;
            instr_ready = 1'b1;
            cur_exp     = tbl[i].data;
            cur_fault   = tbl[i].fault;
            chk("b2b_fready", {31'b0, fetch_ready}, {31'b0, i == 0 || instr_valid});
            tick();
            chk("tbl_valid", {31'b0, instr_valid}, 32'd1);
            chk("tbl_instr", instruction, tbl[i].data);
            chk("tbl_fault", {31'b0, fetch_fault}, {31'b0, tbl[i].fault});
        end
        drain();

        // Consumer stall holds the response.
        fetch(32'h8, 32'h3333_3333, 1'b0);
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fetch_valid = (i == 1);
            fetch_addr  = 32'h0;
            tick();
            chk("stall_instr", instruction, 32'h3333_3333);
            chk("stall_valid", {31'b0, instr_valid}, 32'd1);
            chk("stall_fready", {31'b0, fetch_ready}, 32'd0);
        end
        drain();

        // Load begins while a response is pending.
        fetch(32'h4, 32'h2222_2222, 1'b0);
        instr_ready = 1'b0;
        load_start  = 1'b1;
        tick();
        load_start = 1'b0;
        chk("pend_busy", {31'b0, busy}, 32'd1);
        chk("pend_instr", instruction, 32'h2222_2222);
        chk("pend_fready", {31'b0, fetch_ready}, 32'd0);
        fetch_valid = 1'b1;
        fetch_addr  = 32'h0;
        load_beat(32'h5555_5555, 1'b1);
        fetch_valid = 1'b0;
        chk("pend_done", {31'b0, load_done}, 32'd1);
        chk("pend_valid", {31'b0, instr_valid}, 32'd1);
        chk("pend_hold", instruction, 32'h2222_2222);
        chk("pend_fready2", {31'b0, fetch_ready}, 32'd0);
        drain();
        fetch(32'h0, 32'h5555_5555, 1'b0);
        drain();

        // Reset abandons a load; load_start inside LOAD is ignored.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_beat(32'h6666_6666, 1'b0);
        load_start = 1'b1;
        load_beat(32'h7777_7777, 1'b0);
        load_start = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("mid_busy", {31'b0, busy}, 32'd0);
        chk("mid_valid", {31'b0, instr_valid}, 32'd0);
        chk("mid_lready", {31'b0, load_ready}, 32'd0);
        chk("mid_done", {31'b0, load_done}, 32'd0);
        chk("mid_instr", instruction, NOP);
        rst_n = 1'b1;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        load_beat(32'h8888_8888, 1'b1);
        fetch(32'h0, 32'h8888_8888, 1'b0);
        fetch(32'h4, 32'h7777_7777, 1'b0);
        drain();

        chk("sb_left", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
